total_accumulator: RTL and testbench

Sequential back end of the calculator that sits directly downstream of the one-hot button controller. Consumes the controller's decoded, mutually exclusive commands (enter, number, total, clear) plus its error flag. Combines them with the 8-bit operand switches to keep a saturating 16-bit running total, an entry count and a display value. Turns level-held button commands into single-cycle events so each press acts exactly once.

---
 rtl/total_accumulator_if.sv | 27 ++
 rtl/total_accumulator.sv | 159 +++++++++++++++
 tb/tb_total_accumulator.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/total_accumulator_if.sv
// Bundles the button-controller commands, operand switches and the
// accumulator results into one port so the calculator back end and its
// driver connect through a single named bus.
interface total_accumulator_if;
    logic        enterCmd;
    logic        numberCmd;
    logic        totalCmd;
    logic        clearCmd;
    logic        errIn;
    logic [7:0]  dataIn;
    logic [15:0] total;
    logic [15:0] display;
    logic [7:0]  count;
    logic        overflow;
    logic        errFlag;
    logic [1:0]  mode;

    modport master (
        output enterCmd, numberCmd, totalCmd, clearCmd, errIn, dataIn,
        input  total, display, count, overflow, errFlag, mode
    );

    modport slave (
        input  enterCmd, numberCmd, totalCmd, clearCmd, errIn, dataIn,
        output total, display, count, overflow, errFlag, mode
    );
endinterface

// File: rtl/total_accumulator.sv
// Calculator back end: turns the controller's level-held commands into
// single-cycle events and uses them to keep a saturating 16-bit running
// total, a saturating entry count and the value shown on the display.
// Every output comes straight from a register.
module total_accumulator (
    input  logic               clk,
    input  logic               resetN,
    total_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        SHOW  = 2'd2,
        ERROR = 2'd3
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [15:0] totalReg;
    logic [15:0] nextTotal;
    logic [15:0] displayReg;
    logic [15:0] nextDisplay;
    logic [7:0]  operandReg;
    logic [7:0]  nextOperand;
    logic [7:0]  countReg;
    logic [7:0]  nextCount;
    logic        overflowReg;
    logic        nextOverflow;
    logic        errFlagReg;
    logic        nextErrFlag;

    logic        enterPrev;
    logic        numberPrev;
    logic        totalPrev;
    logic        clearPrev;
    logic        enterEvt;
    logic        numberEvt;
    logic        totalEvt;
    logic        clearEvt;
    logic [16:0] sum;

    assign enterEvt  = bus.enterCmd  & ~enterPrev;
    assign numberEvt = bus.numberCmd & ~numberPrev;
    assign totalEvt  = bus.totalCmd  & ~totalPrev;
    assign clearEvt  = bus.clearCmd  & ~clearPrev;

    assign sum = {1'b0, totalReg} + {9'd0, operandReg};

    // Remember last cycle's command levels so a held button fires only once,
    // including while the FSM sits in ERROR.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            enterPrev  <= 1'b0;
            numberPrev <= 1'b0;
            totalPrev  <= 1'b0;
            clearPrev  <= 1'b0;
        end else begin
            enterPrev  <= bus.enterCmd;
            numberPrev <= bus.numberCmd;
            totalPrev  <= bus.totalCmd;
            clearPrev  <= bus.clearCmd;
        end
    end

    // Register the FSM state together with all datapath state it governs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            totalReg    <= 16'd0;
            displayReg  <= 16'd0;
            operandReg  <= 8'd0;
            countReg    <= 8'd0;
            overflowReg <= 1'b0;
            errFlagReg  <= 1'b0;
        end else begin
            state       <= nextState;
            totalReg    <= nextTotal;
            displayReg  <= nextDisplay;
            operandReg  <= nextOperand;
            countReg    <= nextCount;
            overflowReg <= nextOverflow;
            errFlagReg  <= nextErrFlag;
        end
    end

    // Decide the next state and datapath values; an error level beats a
    // clear, which beats total, then enter, then number. An event a state
    // ignores does not block a lower-priority one.
    always_comb begin
        nextState    = state;
        nextTotal    = totalReg;
        nextDisplay  = displayReg;
        nextOperand  = operandReg;
        nextCount    = countReg;
        nextOverflow = overflowReg;
        nextErrFlag  = errFlagReg;

        if (bus.errIn) begin
            nextState   = ERROR;
            nextErrFlag = 1'b1;
        end else if (clearEvt) begin
            nextState    = IDLE;
            nextTotal    = 16'd0;
            nextDisplay  = 16'd0;
            nextOperand  = 8'd0;
            nextCount    = 8'd0;
            nextOverflow = 1'b0;
            nextErrFlag  = 1'b0;
        end else begin
            case (state)
                IDLE, SHOW: begin
                    if (totalEvt) begin
                        nextState   = SHOW;
                        nextDisplay = totalReg;
                    end else if (numberEvt) begin
                        nextState   = ENTRY;
                        nextOperand = bus.dataIn;
                        nextDisplay = {8'h00, bus.dataIn};
                    end
                end
                ENTRY: begin
                    if (totalEvt) begin
                        nextState   = SHOW;
                        nextOperand = 8'd0;
                        nextDisplay = totalReg;
                    end else if (enterEvt) begin
                        nextState = IDLE;
                        if (sum[16]) begin
                            nextTotal    = 16'hFFFF;
                            nextDisplay  = 16'hFFFF;
                            nextOverflow = 1'b1;
                        end else begin
                            nextTotal   = sum[15:0];
                            nextDisplay = sum[15:0];
                        end
                        if (countReg != 8'hFF) begin
                            nextCount = countReg + 8'd1;
                        end
                    end else if (numberEvt) begin
                        nextOperand = bus.dataIn;
                        nextDisplay = {8'h00, bus.dataIn};
                    end
                end
                default: begin
                    nextState = ERROR;
                end
            endcase
        end
    end

    assign bus.total    = totalReg;
    assign bus.display  = displayReg;
    assign bus.count    = countReg;
    assign bus.overflow = overflowReg;
    assign bus.errFlag  = errFlagReg;
    assign bus.mode     = state;

endmodule

// File: tb/tb_total_accumulator.sv
// Self-checking bench for total_accumulator. The stimulus process drives
// one vector per cycle, advances a plain-arithmetic reference model and
// queues the outputs it expects after the next rising edge; a separate
// monitor pops that queue just after each edge and compares.
module tb_total_accumulator;

    typedef struct packed {
        logic [15:0] total;
        logic [15:0] display;
        logic [7:0]  count;
        logic        overflow;
        logic        errFlag;
        logic [1:0]  mode;
    } outT;

    logic clk;
    logic resetN;
    total_accumulator_if bus();

    total_accumulator dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int  vectors = 0;
    int  miscompares = 0;
    outT expQ[$];

    int  mTotal;
    int  mDisplay;
    int  mCount;
    int  mOperand;
    int  mMode;
    bit  mOverflow;
    bit  mErr;
    bit  pEnter;
    bit  pNumber;
    bit  pTotal;
    bit  pClear;

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void modelReset();
        mTotal    = 0;
        mDisplay  = 0;
        mCount    = 0;
        mOperand  = 0;
        mMode     = 0;
        mOverflow = 1'b0;
        mErr      = 1'b0;
        pEnter    = 1'b0;
        pNumber   = 1'b0;
        pTotal    = 1'b0;
        pClear    = 1'b0;
    endfunction

    function automatic outT modelOut();
        outT o;
        o.total    = 16'(mTotal);
        o.display  = 16'(mDisplay);
        o.count    = 8'(mCount);
        o.overflow = mOverflow;
        o.errFlag  = mErr;
        o.mode     = 2'(mMode);
        return o;
    endfunction

    // Behaviour of one rising edge: mode 0 IDLE, 1 ENTRY, 2 SHOW, 3 ERROR.
    function automatic void modelStep(bit en, bit num, bit tot, bit clr, bit err, int d);
        bit eEnter  = en  && !pEnter;
        bit eNumber = num && !pNumber;
        bit eTotal  = tot && !pTotal;
        bit eClear  = clr && !pClear;
        int s;
        pEnter  = en;
        pNumber = num;
        pTotal  = tot;
        pClear  = clr;
        if (err) begin
            mMode = 3;
            mErr  = 1'b1;
        end else if (eClear) begin
            mTotal    = 0;
            mDisplay  = 0;
            mCount    = 0;
            mOperand  = 0;
            mOverflow = 1'b0;
            mErr      = 1'b0;
            mMode     = 0;
        end else if (mMode != 3) begin
            if (eTotal) begin
                mMode    = 2;
                mDisplay = mTotal;
            end else if (eEnter && mMode == 1) begin
                s = mTotal + mOperand;
                if (s > 65535) begin
                    mTotal    = 65535;
                    mOverflow = 1'b1;
                end else begin
                    mTotal = s;
                end
                mCount   = (mCount < 255) ? mCount + 1 : 255;
                mDisplay = mTotal;
                mMode    = 0;
            end else if (eNumber) begin
                mOperand = d;
                mDisplay = d;
                mMode    = 1;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input outT exp);
        outT act;
        act.total    = bus.total;
        act.display  = bus.display;
        act.count    = bus.count;
        act.overflow = bus.overflow;
        act.errFlag  = bus.errFlag;
        act.mode     = bus.mode;
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s #%0d at %0t: got total=%h display=%h count=%0d overflow=%b errFlag=%b mode=%0d, want total=%h display=%h count=%0d overflow=%b errFlag=%b mode=%0d",
                     tag, vectors, $time, act.total, act.display, act.count, act.overflow,
                     act.errFlag, act.mode, exp.total, exp.display, exp.count, exp.overflow,
                     exp.errFlag, exp.mode);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit num, input bit tot,
                                 input bit clr, input bit err, input logic [7:0] d);
        bus.enterCmd  = en;
        bus.numberCmd = num;
        bus.totalCmd  = tot;
        bus.clearCmd  = clr;
        bus.errIn     = err;
        bus.dataIn    = d;
        modelStep(en, num, tot, clr, err, int'(d));
        expQ.push_back(modelOut());
    endtask

    task automatic step(input bit en, input bit num, input bit tot,
                        input bit clr, input bit err, input logic [7:0] d);
        @(posedge clk);
        #2;
        applyStimulus(en, num, tot, clr, err, d);
    endtask

    task automatic doAdd(input logic [7:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, d);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic doClear();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    initial begin
        outT exp;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                checkOutput("scoreboard", exp);
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized stretch.
    initial begin
        outT zeros;
        zeros = '0;

        resetN        = 1'b0;
        bus.enterCmd  = 1'b0;
        bus.numberCmd = 1'b0;
        bus.totalCmd  = 1'b0;
        bus.clearCmd  = 1'b0;
        bus.errIn     = 1'b0;
        bus.dataIn    = 8'd0;
        modelReset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetState", zeros);
        @(posedge clk);
        #2;
        resetN = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("[TB] held number and enter yield one add");
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd25);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd25);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("[TB] saturation of total and count");
        doClear();
        for (int i = 0; i < 256; i++) doAdd(8'hFF);
        doAdd(8'hF0);
        doAdd(8'hF0);
        doAdd(8'd1);

        $display("[TB] total discards pending operand");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("[TB] error entry and recovery");
        doClear();
        doAdd(8'd100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("[TB] long clear then immediate number");
        doAdd(8'd100);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);

        $display("[TB] asynchronous reset mid-entry");
        doAdd(8'd60);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset", zeros);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #2;
        resetN = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd42);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd42);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd42);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("[TB] randomized command stream");
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 29) == 0, 8'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        #3;
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
